// File: rtl/fetch_stage_pkg.sv
// Shared fetch definitions: widths, FSM state encoding and byte-offset helper.
// Also used by the PC mux and decode stages.
package fetch_stage_pkg;

    localparam int ADDR_W      = 16;
    localparam int INSTR_W     = 24;
    localparam int INSTR_BYTES = 3;

    typedef enum logic [1:0] {
        FETCH0 = 2'd0,
        FETCH1 = 2'd1,
        FETCH2 = 2'd2,
        HOLD   = 2'd3
    } fetch_state_t;

    // Byte offset from PC of the read issued in a fetch state; HOLD points at PC.
    function automatic logic [ADDR_W-1:0] byte_offset(input fetch_state_t st);
        logic [ADDR_W-1:0] off;
        off = '0;
        case (st)
            FETCH1:  off = ADDR_W'(1);
            FETCH2:  off = ADDR_W'(2);
            default: off = '0;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Byte-serial instruction fetch: reads three bytes per instruction, assembles them
// big-endian and holds the result until decode accepts it or a redirect flushes it.
//
// state  | meaning
// FETCH0 | requesting byte 0 at PC
// FETCH1 | requesting byte 1 at PC+1
// FETCH2 | requesting byte 2 at PC+2
// HOLD   | instruction complete, Instr_Valid=1, waiting for Instr_Ready
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  PC_In,
    input  logic               Is_Address_Taken,
    output logic [ADDR_W-1:0]  PC_3,
    output logic [ADDR_W-1:0]  PC,
    output logic               Mem_Req,
    output logic [ADDR_W-1:0]  Mem_Addr,
    input  logic               Mem_Ack,
    input  logic [7:0]         Mem_Data,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  Instr_PC,
    output logic               Instr_Valid,
    input  logic               Instr_Ready
);

    fetch_state_t       state, state_next;
    logic [ADDR_W-1:0]  pc_q, pc_next;
    logic [INSTR_W-1:0] instr_q, instr_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH0;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state   <= state_next;
            pc_q    <= pc_next;
            instr_q <= instr_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        instr_next = instr_q;
        if (Is_Address_Taken) begin
            // Redirect wins over ack and handoff; a same-cycle ack is dropped.
            state_next = FETCH0;
            pc_next    = PC_In;
            instr_next = '0;
        end else begin
            case (state)
                FETCH0: if (Mem_Ack) begin
                    instr_next[23:16] = Mem_Data;
                    state_next        = FETCH1;
                end
                FETCH1: if (Mem_Ack) begin
                    instr_next[15:8] = Mem_Data;
                    state_next       = FETCH2;
                end
                FETCH2: if (Mem_Ack) begin
                    instr_next[7:0] = Mem_Data;
                    state_next      = HOLD;
                end
                HOLD: if (Instr_Ready) begin
                    pc_next    = PC_In;
                    state_next = FETCH0;
                end
                default: state_next = FETCH0;
            endcase
        end
    end

    // rst_n gates the request so it drops immediately on reset and is live in
    // the very first cycle after release.
    assign Mem_Req     = rst_n && (state != HOLD);
    assign Mem_Addr    = pc_q + byte_offset(state);
    assign PC_3        = pc_q + ADDR_W'(INSTR_BYTES);
    assign PC          = pc_q;
    assign Instr_PC    = pc_q;
    assign Instr       = instr_q;
    assign Instr_Valid = (state == HOLD);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, backpressure, ack delay, redirect, wrap,
// redirect-with-handoff and asynchronous reset, against hand-computed values.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_in;
    logic        taken;
    logic [15:0] pc_3;
    logic [15:0] pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [23:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int n_chk = 0;
    int n_bad = 0;

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .PC_In           (pc_in),
        .Is_Address_Taken(taken),
        .PC_3            (pc_3),
        .PC              (pc),
        .Mem_Req         (mem_req),
        .Mem_Addr        (mem_addr),
        .Mem_Ack         (mem_ack),
        .Mem_Data        (mem_data),
        .Instr           (instr),
        .Instr_PC        (instr_pc),
        .Instr_Valid     (instr_valid),
        .Instr_Ready     (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: a few fixed bytes, everything else addr[7:0]^0x5A.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'h0000: return 8'h12;
            16'h0001: return 8'h34;
            16'h0002: return 8'h56;
            16'h0100: return 8'hAA;
            16'h0101: return 8'hBB;
            16'h0102: return 8'hCC;
            16'hFFFE: return 8'h9A;
            16'hFFFF: return 8'hBC;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    always_comb mem_data = mem_byte(mem_addr);

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        pc_in       = 16'h0000;
        taken       = 1'b0;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_pc",    24'(pc), 24'h0000);
        check("rst_req",   24'(mem_req), 24'd0);
        check("rst_valid", 24'(instr_valid), 24'd0);
        check("rst_instr", instr, 24'h000000);
        check("rst_pc3",   24'(pc_3), 24'h0003);
        check("rst_addr",  24'(mem_addr), 24'h0000);

        // Best-case fetch from reset
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        #1;
        check("f0_req",  24'(mem_req), 24'd1);
        check("f0_addr", 24'(mem_addr), 24'h0000);
        @(negedge clk);
        check("f1_addr", 24'(mem_addr), 24'h0001);
        @(negedge clk);
        check("f2_addr", 24'(mem_addr), 24'h0002);
        @(negedge clk);
        check("h_valid", 24'(instr_valid), 24'd1);
        check("h_instr", instr, 24'h123456);
        check("h_ipc",   24'(instr_pc), 24'h0000);
        check("h_pc3",   24'(pc_3), 24'h0003);

        // Backpressure, with acks still arriving (must be ignored)
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_instr", instr, 24'h123456);
            check("bp_ipc",   24'(instr_pc), 24'h0000);
            check("bp_pc",    24'(pc), 24'h0000);
            check("bp_req",   24'(mem_req), 24'd0);
            check("bp_valid", 24'(instr_valid), 24'd1);
        end
        instr_ready = 1'b1;
        pc_in       = 16'h0003;
        @(negedge clk);
        instr_ready = 1'b0;
        check("ho_addr",  24'(mem_addr), 24'h0003);
        check("ho_valid", 24'(instr_valid), 24'd0);
        check("ho_req",   24'(mem_req), 24'd1);

        // Ack delay in FETCH1
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ad_req",  24'(mem_req), 24'd1);
            check("ad_addr", 24'(mem_addr), 24'h0004);
            @(negedge clk);
        end
        check("ad_addr_end", 24'(mem_addr), 24'h0004);
        mem_ack = 1'b1;
        @(negedge clk);
        check("ad_f2", 24'(mem_addr), 24'h0005);
        @(negedge clk);
        check("ad_instr", instr, 24'h595E5F);
        check("ad_ipc",   24'(instr_pc), 24'h0003);
        check("ad_valid", 24'(instr_valid), 24'd1);

        // Redirect after byte 0, with a same-cycle ack
        instr_ready = 1'b1;
        pc_in       = 16'h0006;
        @(negedge clk);
        instr_ready = 1'b0;
        check("rd_f0", 24'(mem_addr), 24'h0006);
        @(negedge clk);
        check("rd_f1", 24'(mem_addr), 24'h0007);
        taken = 1'b1;
        pc_in = 16'h0100;
        @(negedge clk);
        taken = 1'b0;
        check("rd_addr0", 24'(mem_addr), 24'h0100);
        check("rd_pc",    24'(pc), 24'h0100);
        check("rd_valid", 24'(instr_valid), 24'd0);
        @(negedge clk);
        check("rd_addr1", 24'(mem_addr), 24'h0101);
        @(negedge clk);
        check("rd_addr2", 24'(mem_addr), 24'h0102);
        @(negedge clk);
        check("rd_instr", instr, 24'hAABBCC);
        check("rd_ipc",   24'(instr_pc), 24'h0100);
        check("rd_hvalid", 24'(instr_valid), 24'd1);

        // Address wrap
        instr_ready = 1'b1;
        pc_in       = 16'hFFFE;
        @(negedge clk);
        instr_ready = 1'b0;
        check("wr_addr0", 24'(mem_addr), 24'h00FFFE);
        check("wr_pc3",   24'(pc_3), 24'h0001);
        @(negedge clk);
        check("wr_addr1", 24'(mem_addr), 24'h00FFFF);
        @(negedge clk);
        check("wr_addr2", 24'(mem_addr), 24'h0000);
        @(negedge clk);
        check("wr_instr", instr, 24'h9ABC12);
        check("wr_ipc",   24'(instr_pc), 24'h00FFFE);
        check("wr_hpc3",  24'(pc_3), 24'h0001);

        // Redirect together with Instr_Ready in HOLD
        taken       = 1'b1;
        instr_ready = 1'b1;
        pc_in       = 16'h0200;
        @(negedge clk);
        taken       = 1'b0;
        instr_ready = 1'b0;
        check("rh_pc",    24'(pc), 24'h0200);
        check("rh_addr",  24'(mem_addr), 24'h0200);
        check("rh_valid", 24'(instr_valid), 24'd0);

        // Asynchronous reset during FETCH2
        @(negedge clk);
        @(negedge clk);
        check("ar_f2", 24'(mem_addr), 24'h0202);
        #2 rst_n = 1'b0;
        #1;
        check("ar_req",   24'(mem_req), 24'd0);
        check("ar_valid", 24'(instr_valid), 24'd0);
        check("ar_pc",    24'(pc), 24'h0000);
        check("ar_instr", instr, 24'h000000);
        check("ar_addr",  24'(mem_addr), 24'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ar_rel_req",  24'(mem_req), 24'd1);
        check("ar_rel_addr", 24'(mem_addr), 24'h0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: PC_In  input  16  next-PC value selected by the PC mux.
REQ-005 Port: Is_Address_Taken  input  1  redirect/flush strobe; 1 means PC_In holds a branch target.
REQ-006 Port: PC_3  output  16  current PC + 3, fed back to the PC mux.
REQ-007 Port: PC  output  16  current PC register.
REQ-008 Port: Mem_Req  output  1  byte-read request to instruction memory.
REQ-009 Port: Mem_Addr  output  16  byte address of the current request.
REQ-010 Port: Mem_Ack  input  1  memory has read data on Mem_Data this cycle.
REQ-011 Port: Mem_Data  input  8  read byte, valid when Mem_Ack=1.
REQ-012 Port: Instr  output  24  assembled instruction.
REQ-013 Port: Instr_PC  output  16  address of the first byte of Instr.
REQ-014 Port: Instr_Valid  output  1  Instr and Instr_PC are valid for decode.
REQ-015 Port: Instr_Ready  input  1  decode accepts Instr this cycle.

Function
REQ-016 PC_3 SHALL be combinational: PC + 3, truncated to 16 bits (0xFFFE+3 = 0x0001).
REQ-017 The FSM SHALL have four states: FETCH0, FETCH1, FETCH2, HOLD.
REQ-018 In FETCHk (k=0..2), Mem_Req SHALL be 1 and Mem_Addr SHALL be PC+k, modulo 2^16.
REQ-019 Mem_Req SHALL hold with a stable Mem_Addr until Mem_Ack, except on redirect or reset.
REQ-020 On Mem_Ack in FETCHk, Mem_Data SHALL be stored big-endian into Instr[23-8k:16-8k], and the FSM SHALL advance (FETCH2 goes to HOLD).
REQ-021 Mem_Ack outside FETCH0-2 SHALL be ignored.
REQ-022 In HOLD: Instr_Valid=1, Mem_Req=0, Instr_PC=PC.
REQ-023 Instr, Instr_PC and PC SHALL stay stable in HOLD until Instr_Ready=1.
REQ-024 Handoff (HOLD and Instr_Ready=1): PC <= PC_In, FSM goes to FETCH0, and Instr_Valid=0 next cycle.
REQ-025 Instr_Valid SHALL be 0 in every state except HOLD.
REQ-026 Redirect (Is_Address_Taken=1) in any state: PC <= PC_In and FSM goes to FETCH0; it SHALL take priority over Mem_Ack and handoff.
REQ-027 On redirect, partially assembled bytes SHALL be discarded.
REQ-028 On redirect, an ack arriving in the same cycle SHALL be dropped.
REQ-029 On redirect, Mem_Req may deassert without an ack.
REQ-030 Redirect together with Instr_Ready in HOLD SHALL count as a consumed instruction, with PC <= PC_In.
REQ-031 Is_Address_Taken SHALL have no effect beyond the current cycle.
REQ-032 Best-case latency SHALL be 3 cycles from entering FETCH0 to Instr_Valid=1, with Mem_Ack=1 every cycle.

Reset
REQ-033 While rst_n=0, outputs SHALL be immediate (asynchronous): PC=RESET_PC, FSM=FETCH0, Instr=0, Instr_Valid=0.
REQ-034 While rst_n=0, Mem_Req SHALL be 0; Mem_Addr and PC_3 follow PC.
REQ-035 Reset mid-fetch SHALL abandon the transaction without waiting for Mem_Ack.
REQ-036 The first request SHALL be issued in the first cycle after rst_n deasserts.

Structure
REQ-037 A shared fetch package/header SHALL hold the FSM state encodings, INSTR_BYTES=3, ADDR_W=16 and INSTR_W=24, shared with the PC mux and decode.
REQ-038 No sub-module is required; the PC register, +3 adder, byte assembler and FSM SHALL live in fetch_stage.
REQ-039 All outputs except PC_3 and Mem_Addr SHALL be registered or decoded directly from state.

Verification
REQ-040 Reset scenario: RESET_PC=0, memory bytes 0x12,0x34,0x56 at 0..2, Mem_Ack=1 every cycle -> Mem_Addr 0,1,2 on consecutive cycles; then Instr=0x123456, Instr_PC=0, Instr_Valid=1, PC_3=3.
REQ-041 Backpressure scenario: Instr_Ready=0 for 5 cycles in HOLD -> Instr, Instr_PC and PC unchanged, and Mem_Req=0 throughout; Instr_Ready=1 with PC_In=3 -> next cycle Mem_Addr=3 and Instr_Valid=0.
REQ-042 Ack-delay scenario: Mem_Ack withheld 4 cycles in FETCH1 -> Mem_Req=1 and Mem_Addr=PC+1 stable all 4 cycles.
REQ-043 Redirect scenario: after byte 0 is acked, Is_Address_Taken=1 with PC_In=0x0100 and Mem_Ack=1 -> ack dropped; next cycle FETCH0, Mem_Addr=0x0100; the next instruction is assembled from 0x0100-0x0102 only.
REQ-044 Wrap scenario: PC=0xFFFE -> Mem_Addr 0xFFFE, 0xFFFF, 0x0000; PC_3=0x0001; Instr_PC=0xFFFE.
REQ-045 Async reset scenario: rst_n low mid-cycle during FETCH2 -> Mem_Req=0, Instr_Valid=0, PC=RESET_PC before the next clock edge.
